// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared constants for the register file and the logic that feeds it:
//   architectural register indices, the stack-pointer reset value, and the
//   register-destination select encodings used by the dest mux and control.
package register_bank_pkg;

  localparam int          REG_ZERO = 0;
  localparam int          REG_SP   = 29;
  localparam int          REG_RA   = 31;
  localparam logic [31:0] SP_RESET = 32'd227;

  // Register-destination mux select
  typedef enum logic [2:0] {
    RDEST_RT = 3'd0,
    RDEST_RD = 3'd1,
    RDEST_RA = 3'd2,
    RDEST_SP = 3'd3,
    RDEST_RS = 3'd4
  } reg_dest_e;

endpackage

// File: rtl/register_bank.sv
// register_bank
//   2**ADDR_W x DATA_W general-purpose register file with two combinational
//   read ports and one clocked write port. Register 0 is hard-wired to zero.
//   Reset clears every register except the stack pointer, which loads SP_RESET.
//
// Ports
//   clk       : clock, writes on rising edge
//   reset     : asynchronous active-high reset
//   RegWrite  : write enable
//   ReadReg1  : read port A index      -> ReadData1
//   ReadReg2  : read port B index      -> ReadData2
//   WriteReg  : write index
//   WriteData : write data
module register_bank
  import register_bank_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(register_bank_pkg::SP_RESET)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;

  // Writes to register 0 are dropped so it always holds its reset value of 0.
  assign w_wr_en = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= (i == REG_SP) ? SP_RESET : '0;
    end else if (w_wr_en) begin
      r_regs[WriteReg] <= WriteData;
    end
  end

  // No write-to-read bypass: a same-cycle write is visible only after the edge.
  assign ReadData1 = (ReadReg1 == ADDR_W'(REG_ZERO)) ? '0 : r_regs[ReadReg1];
  assign ReadData2 = (ReadReg2 == ADDR_W'(REG_ZERO)) ? '0 : r_regs[ReadReg2];

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData1, ReadData2;

  int tests = 0;
  int fails = 0;

  register_bank dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: architectural contents of the 32 registers
  logic [31:0] mdl [32];

  function automatic logic [31:0] mdl_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : mdl[idx];
  endfunction

  always @(posedge reset)
    for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd227 : 32'd0;

  always @(posedge clk)
    if (!reset && RegWrite && WriteReg != 5'd0) mdl[WriteReg] = WriteData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Continuous compare against the model while the clock runs
  always @(negedge clk) begin
    check("model_rd1", ReadData1, mdl_rd(ReadReg1));
    check("model_rd2", ReadData2, mdl_rd(ReadReg2));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset pulse with the clock stopped
    #3 reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      check("rst_rd1", ReadData1, (i == 29) ? 32'd227 : 32'd0);
      check("rst_rd2", ReadData2, ((31 - i) == 29) ? 32'd227 : 32'd0);
    end
    ReadReg1 = '0; ReadReg2 = '0;
    clk_en = 1'b1;
    step();

    // Basic write, then RegWrite=0 holds
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd8;
    step();
    check("wr8", ReadData1, 32'hDEADBEEF);
    RegWrite = 1'b0; WriteData = 32'h1;
    step();
    check("hold8", ReadData1, 32'hDEADBEEF);

    // Writes to register 0 are ignored
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    step();
    check("r0_rd1", ReadData1, 32'd0);
    check("r0_rd2", ReadData2, 32'd0);

    // ra: old value before edge, new value after (no bypass)
    WriteReg = 5'd31; WriteData = 32'h11; ReadReg2 = 5'd31;
    step();
    check("ra_first", ReadData2, 32'h11);
    WriteData = 32'h44;
    #1;
    check("ra_old", ReadData2, 32'h11);
    step();
    check("ra_new", ReadData2, 32'h44);

    // sp write, then reset mid-cycle with RegWrite=1
    WriteReg = 5'd29; WriteData = 32'h100; ReadReg1 = 5'd29; ReadReg2 = 5'd8;
    step();
    check("sp_wr", ReadData1, 32'h100);
    WriteData = 32'h55;
    #2 reset = 1'b1;
    #1;
    check("sp_rst", ReadData1, 32'd227);
    check("r8_rst", ReadData2, 32'd0);
    step();   // edge with reset=1 and RegWrite=1: suppressed
    check("sp_rst_hold", ReadData1, 32'd227);
    #2 reset = 1'b0;
    step();   // first edge after deassertion writes
    check("sp_post_rst", ReadData1, 32'h55);

    // Fill regs 1..31 with index*3 and read pairs (i, 32-i)
    for (int i = 1; i < 32; i++) begin
      WriteReg = 5'(i); WriteData = 32'(i * 3);
      step();
    end
    RegWrite = 1'b0;
    for (int i = 1; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(32 - i);
      #1;
      check("pair_rd1", ReadData1, 32'(i * 3));
      check("pair_rd2", ReadData2, 32'((32 - i) * 3));
    end
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1;
    check("pair_r0", ReadData1, 32'd0);
    ReadReg1 = 5'd17; ReadReg2 = 5'd17;
    #1;
    check("same_idx", ReadData1, ReadData2 === 32'd51 ? 32'd51 : ~ReadData1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
